td4_sequencer: RTL
==================

Name: td4_sequencer

Overview:
- Control and sequencing stage for the 4-bit TTM4 datapath, directly upstream of the A/B/OUT registers.
- Holds the program counter (PC) and the carry flag, and decodes the 8-bit instruction from program ROM.
- Drives the active-low store strobes (nA_ST, nB_ST, nOUT_ST) and the tri-state bus-source enables (nA_OUT, nB_OUT, nIN_OUT) consumed by the register stages.
- Adds run/halt/single-step control.

Parameters:
RESET_RUN, 1, 1 = enter RUN after reset; 0 = enter HALT.
SYNC_STAGES, 2, flip-flop stages that synchronise the asynchronous STEP and RUN_REQ inputs (minimum 2).

Ports:
CLK  input  1  system clock; every flop updates on its rising edge.
RST  input  1  asynchronous, active-low reset.
RUN_REQ  input  1  level: 1 = run freely, 0 = halt (asynchronous input; synchronised internally).
STEP  input  1  rising edge executes exactly one instruction while halted (asynchronous input; synchronised internally).
ROM_DATA  input  8  instruction at PC_ADDR: [7:4] opcode, [3:0] immediate.
ALU_CARRY  input  1  adder carry-out for the current cycle.
PC_ADDR  output  4  program counter, ROM address.
IMM  output  4  ROM_DATA[3:0], passed to the ALU immediate operand.
nA_OUT, nB_OUT, nIN_OUT  output  1 each  active-low bus-source enables; at most one is low; none low selects zero.
nA_ST, nB_ST, nOUT_ST  output  1 each  active-low store strobes for register A, register B and the output port.
C_FLAG  output  1  registered carry flag.
RUNNING  output  1  1 in the RUN state.
EXEC  output  1  1 in a cycle that commits an instruction.

Behaviour:
- Reset (RST=0, asynchronous):
  - PC=0, C_FLAG=0, synchroniser chains cleared, state = RUN if RESET_RUN=1, otherwise HALT.
  - All six active-low outputs forced to 1.
  - EXEC=0; RUNNING reflects the reset state.
- States:
  - RUN → HALT when synced RUN_REQ=0.
  - HALT → RUN when synced RUN_REQ=1.
  - In HALT, the first synced cycle where STEP goes 0→1 produces a one-cycle step pulse.
  - Decisions take effect on the cycle after synchronisation; there is no further latency.
- EXEC = (state==RUN) | step_pulse. The step pulse is ignored in RUN.
- Decode is combinational from ROM_DATA, so PC→ROM→strobes settle within the same cycle.
- Strobes and bus enables are active only when EXEC=1. When EXEC=0, all six are 1 and PC/C_FLAG hold.
- Opcodes (source; strobe):
  - 0000 ADD A,Im: A; nA_ST
  - 0101 ADD B,Im: B; nB_ST
  - 0011 MOV A,Im: zero; nA_ST
  - 0111 MOV B,Im: zero; nB_ST
  - 0001 MOV A,B: B; nA_ST
  - 0100 MOV B,A: A; nB_ST
  - 0010 IN A: IN; nA_ST
  - 0110 IN B: IN; nB_ST
  - 1001 OUT B: B; nOUT_ST
  - 1011 OUT Im: zero; nOUT_ST
  - 1111 JMP Im: zero; no strobe
  - 1110 JNC Im: zero; no strobe
  - All other opcodes: NOP, with no source and no strobe.
- PC update on an EXEC edge:
  - JMP: PC ← Im.
  - JNC with C_FLAG=0: PC ← Im.
  - JNC with C_FLAG=1: PC ← PC+1.
  - All other opcodes: PC ← PC+1, modulo 16 (15 wraps to 0).
- C_FLAG ← ALU_CARRY on every EXEC edge, including NOP and jumps.
- JNC tests the C_FLAG value from before the edge, not ALU_CARRY.
- Simultaneous events:
  - RUN_REQ falling in the same cycle as a step pulse: the state goes to HALT and the step still executes once.
  - RST assertion mid-instruction aborts it with no partial PC/C_FLAG update.
- Deassertion of RST is synchronised by the surrounding design. The block adds nothing for it.

Test Plan:
- Reset: RST=0 with RESET_RUN=1, ROM_DATA=0x31 → PC=0, C_FLAG=0, all strobes and enables 1. After release, first edge: nA_ST=0 with no enable low, PC→1.
- Decode sweep: in RUN, hold each of the 16 opcodes with Im=0x5 → strobe and enable pattern matches the table, IMM=0x5. Opcodes 1000, 1010, 1100 and 1101 give all outputs 1 and PC+1.
- Jumps:
  - ROM_DATA=0xF9 → PC=9.
  - JNC 0xE3 with C_FLAG=1 → PC=10.
  - Drive ALU_CARRY=0 for one EXEC so C_FLAG=0, then JNC 0xE3 → PC=3.
- Wrap: PC=15 with NOP → PC=0. Check C_FLAG follows ALU_CARRY=1 then 0 across successive EXEC edges.
- Halt/step:
  - Drop RUN_REQ → PC freezes two or three cycles later and RUNNING=0.
  - Apply three STEP pulses (each held ≥4 cycles) → PC advances exactly 3 with three one-cycle EXEC pulses.
  - STEP held high → no further advance.
- Mid-op reset: assert RST during a JMP cycle → PC=0 immediately (asynchronous) and no jump is taken after release.

Source files
------------

// File: rtl/td4_sequencer.sv
// TD4 control stage: program counter, carry flag, instruction decode and
// run/halt/single-step control feeding the A/B/OUT register stages.
module td4_sequencer #(
    parameter int unsigned RESET_RUN   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN_REQ,
    input  logic       STEP,
    input  logic [7:0] ROM_DATA,
    input  logic       ALU_CARRY,
    output logic [3:0] PC_ADDR,
    output logic [3:0] IMM,
    output logic       nA_OUT,
    output logic       nB_OUT,
    output logic       nIN_OUT,
    output logic       nA_ST,
    output logic       nB_ST,
    output logic       nOUT_ST,
    output logic       C_FLAG,
    output logic       RUNNING,
    output logic       EXEC
);

    localparam int unsigned STAGES   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic        RUN_INIT = (RESET_RUN != 0);

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          pc_q, pc_d;
    logic                c_flag_q, c_flag_d;
    logic [STAGES-1:0]   run_sync_q, run_sync_d;
    logic [STAGES-1:0]   step_sync_q, step_sync_d;
    logic                step_prev_q, step_prev_d;

    logic                run_synced;
    logic                step_synced;
    logic                step_pulse;
    logic                exec;
    logic [3:0]          opcode;
    logic [3:0]          imm;

    assign opcode      = ROM_DATA[7:4];
    assign imm         = ROM_DATA[3:0];
    assign run_synced  = run_sync_q[STAGES-1];
    assign step_synced = step_sync_q[STAGES-1];

    // The RUN_REQ chain resets to the reset state's own run level, so the
    // block does not bounce through HALT while the chain refills after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= RUN_INIT ? ST_RUN : ST_HALT;
            pc_q        <= '0;
            c_flag_q    <= 1'b0;
            run_sync_q  <= {STAGES{RUN_INIT}};
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            c_flag_q    <= c_flag_d;
            run_sync_q  <= run_sync_d;
            step_sync_q <= step_sync_d;
            step_prev_q <= step_prev_d;
        end
    end

    always_comb begin
        run_sync_d  = {run_sync_q[STAGES-2:0], RUN_REQ};
        step_sync_d = {step_sync_q[STAGES-2:0], STEP};
        step_prev_d = step_synced;
        step_pulse  = (state_q == ST_HALT) && step_synced && !step_prev_q;
        exec        = RST && ((state_q == ST_RUN) || step_pulse);
        state_d     = run_synced ? ST_RUN : ST_HALT;

        pc_d     = pc_q;
        c_flag_d = c_flag_q;
        if (exec) begin
            c_flag_d = ALU_CARRY;
            if (opcode == 4'b1111 || (opcode == 4'b1110 && !c_flag_q)) begin
                pc_d = imm;
            end else begin
                pc_d = pc_q + 4'd1;
            end
        end
    end

    always_comb begin
        nA_OUT  = 1'b1;
        nB_OUT  = 1'b1;
        nIN_OUT = 1'b1;
        nA_ST   = 1'b1;
        nB_ST   = 1'b1;
        nOUT_ST = 1'b1;
        if (exec) begin
            unique case (opcode)
                4'b0000: begin nA_OUT  = 1'b0; nA_ST   = 1'b0; end
                4'b0101: begin nB_OUT  = 1'b0; nB_ST   = 1'b0; end
                4'b0011: begin                 nA_ST   = 1'b0; end
                4'b0111: begin                 nB_ST   = 1'b0; end
                4'b0001: begin nB_OUT  = 1'b0; nA_ST   = 1'b0; end
                4'b0100: begin nA_OUT  = 1'b0; nB_ST   = 1'b0; end
                4'b0010: begin nIN_OUT = 1'b0; nA_ST   = 1'b0; end
                4'b0110: begin nIN_OUT = 1'b0; nB_ST   = 1'b0; end
                4'b1001: begin nB_OUT  = 1'b0; nOUT_ST = 1'b0; end
                4'b1011: begin                 nOUT_ST = 1'b0; end
                default: begin end
            endcase
        end
    end

    assign PC_ADDR = pc_q;
    assign IMM     = imm;
    assign C_FLAG  = c_flag_q;
    assign RUNNING = (state_q == ST_RUN);
    assign EXEC    = exec;

endmodule
